// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Address width for n registers; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Pending-load scoreboard: busy bits, their population count, sticky protocol error
// and the per-read-port busy lookup with same-cycle load-return bypass.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = aw_of(NREG),
    localparam int CW   = $clog2(NREG + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic              res_en,
    input  logic [AW-1:0]     res_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [CW-1:0]     busy_cnt,
    output logic              err
);

    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic            w_clr_v;
    logic            w_res_v;
    logic            w_same;
    logic            w_inc;
    logic            w_dec;
    logic            w_err_set;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW-1:0]   w_ra;

    // Classify this cycle's clear/reserve; a same-address pair means a new miss replaces the old one.
    always_comb begin
        w_clr_v   = wb_en && (wb_addr != {AW{1'b0}});
        w_res_v   = res_en && (res_addr != {AW{1'b0}});
        w_same    = w_clr_v && w_res_v && (wb_addr == res_addr);
        w_inc     = w_res_v && !r_busy[res_addr];
        w_dec     = w_clr_v && r_busy[wb_addr] && !w_same;
        w_err_set = (w_clr_v && !r_busy[wb_addr] && !w_same) ||
                    (w_res_v && r_busy[res_addr] && !w_same);
        w_busy_nxt    = {NREG{1'b0}};
        for (int j = 1; j < NREG; j++) begin
            w_busy_nxt[j] = (w_res_v && (res_addr == AW'(j))) ||
                            (r_busy[j] && !(w_clr_v && (wb_addr == AW'(j))));
        end
    end

    // Scoreboard state update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy <= {NREG{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + CW'(w_inc) - CW'(w_dec);
            r_err  <= r_err | w_err_set;
        end
    end

    // Read-port busy lookup; a load returning this cycle already satisfies the reader.
    always_comb begin
        rd_busy = {NRD{1'b0}};
        w_ra    = {AW{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            w_ra = rd_addr[i*AW +: AW];
            if (RST) begin
                rd_busy[i] = 1'b0;
            end else begin
                rd_busy[i] = r_busy[w_ra] && !(wb_en && (wb_addr == w_ra));
            end
        end
    end

    assign busy_cnt = r_cnt;
    assign err      = r_err;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with ALU and load-return write ports,
// write-first read bypass and an attached pending-load scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = aw_of(NREG),
    localparam int CW   = $clog2(NREG + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                res_en,
    input  logic [AW-1:0]       res_addr,
    output logic [CW-1:0]       busy_cnt,
    output logic                err
);

    logic [XLEN-1:0] r_data [NREG];

    logic            w_wa_v;
    logic            w_wb_v;
    logic [AW-1:0]   w_ra;

    assign w_wa_v = wa_en && (wa_addr != {AW{1'b0}});
    assign w_wb_v = wb_en && (wb_addr != {AW{1'b0}});

    // Data array; port A is written last so it wins an address collision with port B.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int j = 0; j < NREG; j++) begin
                r_data[j] <= {XLEN{1'b0}};
            end
        end else begin
            if (w_wb_v) begin
                r_data[wb_addr] <= wb_data;
            end
            if (w_wa_v) begin
                r_data[wa_addr] <= wa_data;
            end
        end
    end

    // Write-first read muxes with the same A-over-B priority as the array.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        w_ra    = {AW{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            w_ra = rd_addr[i*AW +: AW];
            if (RST || (w_ra == {AW{1'b0}})) begin
                rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (wa_en && (wa_addr == w_ra)) begin
                rd_data[i*XLEN +: XLEN] = wa_data;
            end else if (wb_en && (wb_addr == w_ra)) begin
                rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = r_data[w_ra];
            end
        end
    end

    regfile_busy_tracker #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_busy (
        .CLK      (CLK),
        .RST      (RST),
        .rd_addr  (rd_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .res_en   (res_en),
        .res_addr (res_addr),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt),
        .err      (err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wa_en;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                res_en;
    logic [AW-1:0]       res_addr;
    logic [CW-1:0]       busy_cnt;
    logic                err;

    logic [XLEN-1:0] m_data [NREG];
    bit              m_busy [NREG];
    bit              m_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    regfile_sb dut (
        .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .res_en(res_en), .res_addr(res_addr), .busy_cnt(busy_cnt), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected read value from architectural state plus this cycle's writes.
    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        if (RST || a == 0) return '0;
        if (wa_en && wa_addr == a) return wa_data;
        if (wb_en && wb_addr == a) return wb_data;
        return m_data[a];
    endfunction

    function automatic bit m_rbusy(input logic [AW-1:0] a);
        if (RST) return 1'b0;
        return m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic int m_pop();
        int c = 0;
        for (int j = 0; j < NREG; j++) c += int'(m_busy[j]);
        return c;
    endfunction

    // Apply the clock-edge rules to the model.
    task automatic m_step();
        if (RST) begin
            for (int j = 0; j < NREG; j++) begin m_data[j] = '0; m_busy[j] = 0; end
            m_err = 0;
        end else begin
            if (wb_en && wb_addr != 0 && !m_busy[wb_addr] && !(res_en && res_addr == wb_addr)) m_err = 1;
            if (res_en && res_addr != 0 && m_busy[res_addr] && !(wb_en && wb_addr == res_addr)) m_err = 1;
            if (wb_en && wb_addr != 0) begin m_data[wb_addr] = wb_data; m_busy[wb_addr] = 0; end
            if (wa_en && wa_addr != 0) m_data[wa_addr] = wa_data;
            if (res_en && res_addr != 0) m_busy[res_addr] = 1;
        end
    endtask

    task automatic drv(input logic a_en, input int a_ad, input logic [XLEN-1:0] a_d,
                       input logic b_en, input int b_ad, input logic [XLEN-1:0] b_d,
                       input logic r_en, input int r_ad, input int ra0, input int ra1);
        wa_en = a_en; wa_addr = AW'(a_ad); wa_data = a_d;
        wb_en = b_en; wb_addr = AW'(b_ad); wb_data = b_d;
        res_en = r_en; res_addr = AW'(r_ad);
        rd_addr = {AW'(ra1), AW'(ra0)};
        #1;
    endtask

    // Check combinational outputs, cross the edge, then check registered outputs.
    task automatic run_cycle();
        logic [AW-1:0] a;
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i*AW +: AW];
            chk($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(m_read(a)));
            chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(m_rbusy(a)));
        end
        @(posedge CLK);
        m_step();
        @(negedge CLK);
        chk("busy_cnt", 64'(busy_cnt), 64'(m_pop()));
        chk("err", 64'(err), 64'(m_err));
    endtask

    initial begin
        for (int j = 0; j < NREG; j++) begin m_data[j] = '0; m_busy[j] = 0; end
        m_err = 0;
        RST = 1'b1;
        @(negedge CLK);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        run_cycle();
        run_cycle();
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        RST = 1'b0;

        drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
        chk("x5_bypass", 64'(rd_data[31:0]), 64'hDEADBEEF);
        run_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
        chk("x5_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("x5_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
        chk("x5_busy", 64'(rd_busy), 64'd0);
        run_cycle();

        drv(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0);
        chk("x0_rd", 64'(rd_data), 64'd0);
        run_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_rd2", 64'(rd_data), 64'd0);
        chk("x0_cnt", 64'(busy_cnt), 64'd0);
        chk("x0_err", 64'(err), 64'd0);
        run_cycle();

        drv(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
        chk("x7_res_same", 64'(rd_busy), 64'd0);
        run_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        chk("x7_busy", 64'(rd_busy), 64'd3);
        chk("x7_cnt1", 64'(busy_cnt), 64'd1);
        run_cycle();
        drv(0, 0, 0, 1, 7, 32'hCAFE0001, 0, 0, 7, 7);
        chk("x7_byp", 64'(rd_data[31:0]), 64'hCAFE0001);
        chk("x7_clr", 64'(rd_busy), 64'd0);
        run_cycle();
        chk("x7_cnt0", 64'(busy_cnt), 64'd0);

        drv(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
        run_cycle();
        drv(1, 9, 32'h11, 1, 9, 32'h22, 0, 0, 9, 9);
        chk("x9_awins", 64'(rd_data[31:0]), 64'h11);
        run_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        chk("x9_after", 64'(rd_data[63:32]), 64'h11);
        chk("x9_nbusy", 64'(rd_busy), 64'd0);
        run_cycle();

        drv(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
        run_cycle();
        drv(0, 0, 0, 1, 3, 32'h33, 1, 3, 3, 3);
        run_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        chk("x3_busy", 64'(rd_busy), 64'd3);
        chk("x3_cnt", 64'(busy_cnt), 64'd1);
        chk("x3_err", 64'(err), 64'd0);
        run_cycle();
        drv(0, 0, 0, 1, 4, 32'h44, 0, 0, 4, 3);
        run_cycle();
        chk("x4_err", 64'(err), 64'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 4, 3);
        run_cycle();
        chk("err_sticky", 64'(err), 64'd1);

        drv(0, 0, 0, 0, 0, 0, 1, 10, 10, 11);
        run_cycle();
        drv(0, 0, 0, 0, 0, 0, 1, 11, 10, 11);
        run_cycle();
        chk("cnt3", 64'(busy_cnt), 64'd3);
        RST = 1'b1;
        drv(1, 10, 32'h5, 0, 0, 0, 0, 0, 10, 5);
        chk("rst_rd", 64'(rd_data), 64'd0);
        chk("rst_rb", 64'(rd_busy), 64'd0);
        run_cycle();
        RST = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 10, 5);
        chk("post_cnt", 64'(busy_cnt), 64'd0);
        chk("post_err", 64'(err), 64'd0);
        chk("post_rd", 64'(rd_data), 64'd0);
        run_cycle();

        for (int n = 0; n < 600; n++) begin
            RST = ($urandom_range(0, 39) == 0);
            drv($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                ($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom,
                ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
